// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU widths, normalize/round FSM states and binary32 layout
package fpu_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 24;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } norm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-2:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// rtl/fp_norm_round_if.sv - operand bundle in, packed binary32 result out, valid/ready on both sides
interface fp_norm_round_if;
    import fpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mant_in;
    logic              carry_in;
    logic [2:0]        grs_in;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       result;
    logic              flag_zero;
    logic              flag_ovf;
    logic              flag_unf;

    modport master (
        output in_valid, sign_in, exp_in, mant_in, carry_in, grs_in, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_ovf, flag_unf
    );

    modport slave (
        input  in_valid, sign_in, exp_in, mant_in, carry_in, grs_in, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_ovf, flag_unf
    );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even on a normalized mantissa with g/r/s
module fp_round_rne
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    input  logic [2:0]        grs_i,
    input  logic [EXP_W:0]    exp_i,
    output logic [MANT_W-1:0] mant_o,
    output logic [EXP_W:0]    exp_o,
    output logic              ovf_o
);

    localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
    localparam logic [EXP_W:0] EXP_SAT = (EXP_W+1)'(EXP_MAX);

    logic              inc;
    logic [MANT_W:0]   sum;

    always_comb begin
        inc = grs_i[2] & (grs_i[1] | grs_i[0] | mant_i[0]);
        sum = {1'b0, mant_i} + {{MANT_W{1'b0}}, inc};
        // A carry out of the top bit leaves an all-zero mantissa; renormalize to 1.0.
        if (sum[MANT_W]) begin
            mant_o = {1'b1, {(MANT_W-1){1'b0}}};
            exp_o  = exp_i + EXP_ONE;
        end else begin
            mant_o = sum[MANT_W-1:0];
            exp_o  = exp_i;
        end
        ovf_o = (exp_o >= EXP_SAT);
    end

endmodule

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - post-adder stage: iterative renormalize, RNE round, pack binary32
module fp_norm_round
    import fpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fp_norm_round_if.slave bus
);

    localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

    norm_state_t       state_q, state_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [2:0]        grs_q, grs_d;
    logic              carry_pend_q, carry_pend_d;
    logic              sign_q, sign_d;
    logic              zero_q, zero_d;
    fp32_t             result_q, result_d;
    logic              flag_zero_q, flag_zero_d;
    logic              flag_ovf_q, flag_ovf_d;
    logic              flag_unf_q, flag_unf_d;

    logic              is_zero;
    logic              norm_stop;
    logic [MANT_W-1:0] rnd_mant;
    logic [EXP_W:0]    rnd_exp;
    logic              rnd_ovf;
    logic [EXP_W-1:0]  exp_field;

    assign is_zero   = (mant_q == '0) && (grs_q == '0);
    assign norm_stop = is_zero || mant_q[MANT_W-1] || (exp_q == EXP_ONE);

    fp_round_rne u_round (
        .mant_i (mant_q),
        .grs_i  (grs_q),
        .exp_i  (exp_q),
        .mant_o (rnd_mant),
        .exp_o  (rnd_exp),
        .ovf_o  (rnd_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = NORM;
            NORM:    if (carry_pend_q || norm_stop) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.flag_zero = flag_zero_q;
        bus.flag_ovf  = flag_ovf_q;
        bus.flag_unf  = flag_unf_q;
    end

    always_comb begin
        exp_d        = exp_q;
        mant_d       = mant_q;
        grs_d        = grs_q;
        carry_pend_d = carry_pend_q;
        sign_d       = sign_q;
        zero_d       = zero_q;
        result_d     = result_q;
        flag_zero_d  = flag_zero_q;
        flag_ovf_d   = flag_ovf_q;
        flag_unf_d   = flag_unf_q;
        // Subnormals keep a field of 0 unless rounding promoted the hidden bit.
        exp_field    = rnd_mant[MANT_W-1] ? rnd_exp[EXP_W-1:0] : '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d       = bus.sign_in;
                    exp_d        = (bus.exp_in == '0) ? EXP_ONE : {1'b0, bus.exp_in};
                    mant_d       = bus.mant_in;
                    grs_d        = bus.grs_in;
                    carry_pend_d = bus.carry_in;
                    zero_d       = 1'b0;
                end
            end
            NORM: begin
                if (carry_pend_q) begin
                    mant_d       = {1'b1, mant_q[MANT_W-1:1]};
                    grs_d        = {mant_q[0], grs_q[2], grs_q[1] | grs_q[0]};
                    exp_d        = exp_q + EXP_ONE;
                    carry_pend_d = 1'b0;
                end else if (is_zero) begin
                    zero_d = 1'b1;
                end else if (!norm_stop) begin
                    // Sticky stays put below a freshly zeroed round bit.
                    mant_d = {mant_q[MANT_W-2:0], grs_q[2]};
                    grs_d  = {grs_q[1], 1'b0, grs_q[0]};
                    exp_d  = exp_q - EXP_ONE;
                end
            end
            ROUND: begin
                if (zero_q) begin
                    result_d    = '0;
                    flag_zero_d = 1'b1;
                    flag_ovf_d  = 1'b0;
                    flag_unf_d  = 1'b0;
                end else if (rnd_ovf) begin
                    result_d.sign = sign_q;
                    result_d.exp  = '1;
                    result_d.frac = '0;
                    flag_zero_d   = 1'b0;
                    flag_ovf_d    = 1'b1;
                    flag_unf_d    = 1'b0;
                end else begin
                    result_d.sign = sign_q;
                    result_d.exp  = exp_field;
                    result_d.frac = rnd_mant[MANT_W-2:0];
                    flag_zero_d   = 1'b0;
                    flag_ovf_d    = 1'b0;
                    flag_unf_d    = (exp_field == '0) && (rnd_mant != '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q        <= '0;
            mant_q       <= '0;
            grs_q        <= '0;
            carry_pend_q <= 1'b0;
            sign_q       <= 1'b0;
            zero_q       <= 1'b0;
            result_q     <= '0;
            flag_zero_q  <= 1'b0;
            flag_ovf_q   <= 1'b0;
            flag_unf_q   <= 1'b0;
        end else begin
            exp_q        <= exp_d;
            mant_q       <= mant_d;
            grs_q        <= grs_d;
            carry_pend_q <= carry_pend_d;
            sign_q       <= sign_d;
            zero_q       <= zero_d;
            result_q     <= result_d;
            flag_zero_q  <= flag_zero_d;
            flag_ovf_q   <= flag_ovf_d;
            flag_unf_q   <= flag_unf_d;
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - directed vectors against a value-level normalize/round model
module tb_fp_norm_round;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_norm_round_if bus();

    fp_norm_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int ov_count = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        z, o, u;
        int          lat;
        int          id;
    } exp_t;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        c;
        logic [2:0]  g;
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    exp_t expq[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Value view: {carry, mant, g, r} plus a separate sticky; shift until the hidden bit is set.
    function automatic exp_t model(input logic s, input logic [7:0] e_in, input logic [23:0] m_in,
                                   input logic c_in, input logic [2:0] grs);
        exp_t        r;
        int          e;
        int          k;
        logic [26:0] sig;
        logic        st;
        logic [24:0] m;
        logic        inc;
        logic [7:0]  ef;
        r.z = 1'b0; r.o = 1'b0; r.u = 1'b0; r.id = 0;
        e   = (e_in == 8'd0) ? 1 : int'(e_in);
        sig = {c_in, m_in, grs[2:1]};
        st  = grs[0];
        k   = 0;
        if (c_in) begin
            st  = st | sig[0];
            sig = sig >> 1;
            e   = e + 1;
        end else if (sig == 27'd0 && st == 1'b0) begin
            r.res = 32'h0;
            r.z   = 1'b1;
            r.lat = 3;
            return r;
        end else begin
            while (sig[25] == 1'b0 && e > 1) begin
                sig = sig << 1;
                e   = e - 1;
                k   = k + 1;
            end
        end
        m   = {1'b0, sig[25:2]};
        inc = sig[1] & (sig[0] | st | m[0]);
        m   = m + {24'd0, inc};
        if (m[24]) begin
            m = 25'h0800000;
            e = e + 1;
        end
        r.lat = 3 + k;
        if (e >= 255) begin
            r.res = {s, 8'hFF, 23'h0};
            r.o   = 1'b1;
        end else begin
            ef    = m[23] ? e[7:0] : 8'h0;
            r.res = {s, ef, m[22:0]};
            r.u   = (ef == 8'h0) && (m[22:0] != 23'h0);
        end
        return r;
    endfunction

    task automatic add(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c,
                       input logic [2:0] g, input logic [31:0] res, input logic [2:0] flags, input int lat);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.c = c; v.g = g; v.res = res; v.flags = flags; v.lat = lat;
        vecs.push_back(v);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.out_valid) begin
                ov_count++;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out_valid: got result %h want no output", bus.result);
                end else begin
                    check($sformatf("result_v%0d", expq[0].id), bus.result, expq[0].res);
                    check($sformatf("flags_v%0d", expq[0].id),
                          32'({bus.flag_zero, bus.flag_ovf, bus.flag_unf}),
                          32'({expq[0].z, expq[0].o, expq[0].u}));
                    check($sformatf("in_ready_busy_v%0d", expq[0].id), 32'(bus.in_ready), 32'd0);
                    if (!ov_prev)
                        check($sformatf("latency_v%0d", expq[0].id), 32'(cyc - acc_cyc + 1), 32'(expq[0].lat));
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready && expq.size() > 0)
            void'(expq.pop_front());
    end

    task automatic send(input int i);
        exp_t ex;
        int   n;
        ex    = model(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].c, vecs[i].g);
        ex.id = i;
        @(negedge clk);
        bus.sign_in  = vecs[i].s;
        bus.exp_in   = vecs[i].e;
        bus.mant_in  = vecs[i].m;
        bus.carry_in = vecs[i].c;
        bus.grs_in   = vecs[i].g;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout_v%0d: in_ready got 0 want 1", i);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        expq.push_back(ex);
        #1 acc_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input int i, input int hold);
        int n;
        bus.out_ready = (hold == 0);
        send(i);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            total++;
            bad++;
            $display("FAIL out_valid_timeout_v%0d: out_valid got 0 want 1", i);
            bus.out_ready = 1'b1;
            expq.delete();
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check($sformatf("ret_out_valid_v%0d", i), 32'(bus.out_valid), 32'd0);
        check($sformatf("ret_in_ready_v%0d", i), 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        exp_t ex;
        int   ov_before;

        bus.in_valid  = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = 8'h0;
        bus.mant_in   = 24'h0;
        bus.carry_in  = 1'b0;
        bus.grs_in    = 3'b000;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", bus.result, 32'h0);
        check("reset_flags", 32'({bus.flag_zero, bus.flag_ovf, bus.flag_unf}), 32'd0);

        //  s  exp     mant         c  grs     result          {z,o,u} lat
        add(0, 8'h80, 24'h800000, 1, 3'b000, 32'h40C00000, 3'b000, 3);
        add(0, 8'h7F, 24'h000001, 0, 3'b000, 32'h34000000, 3'b000, 26);
        add(1, 8'h90, 24'h000000, 0, 3'b000, 32'h00000000, 3'b100, 3);
        add(0, 8'h7F, 24'h800001, 0, 3'b100, 32'h3F800002, 3'b000, 3);
        add(0, 8'h7F, 24'h800000, 0, 3'b100, 32'h3F800000, 3'b000, 3);
        add(0, 8'h7F, 24'h800000, 0, 3'b101, 32'h3F800001, 3'b000, 3);
        add(0, 8'hFE, 24'hFFFFFF, 0, 3'b110, 32'h7F800000, 3'b010, 3);
        add(0, 8'h03, 24'h000100, 0, 3'b000, 32'h00000400, 3'b001, 5);
        add(0, 8'h00, 24'h7FFFFF, 0, 3'b110, 32'h00800000, 3'b000, 3);
        add(1, 8'h85, 24'h400003, 0, 3'b011, 32'hC2000007, 3'b000, 4);
        add(0, 8'hFE, 24'h800000, 1, 3'b000, 32'h7F800000, 3'b010, 3);
        add(0, 8'h05, 24'h000000, 0, 3'b001, 32'h00000000, 3'b000, 7);

        foreach (vecs[i]) begin
            ex = model(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].c, vecs[i].g);
            check($sformatf("model_res_v%0d", i), ex.res, vecs[i].res);
            check($sformatf("model_flags_v%0d", i), 32'({ex.z, ex.o, ex.u}), 32'(vecs[i].flags));
            check($sformatf("model_lat_v%0d", i), 32'(ex.lat), 32'(vecs[i].lat));
        end

        run_vec(0, 5);
        for (int i = 1; i < vecs.size(); i++) run_vec(i, 0);

        // Abort a long cancellation mid-NORM; nothing may come out afterwards.
        bus.out_ready = 1'b1;
        send(1);
        repeat (6) @(negedge clk);
        check("abort_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        ov_before = ov_count;
        repeat (40) @(negedge clk);
        check("abort_no_output", 32'(ov_count - ov_before), 32'd0);

        run_vec(3, 0);
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
Sequential post-adder stage of the FPU single-precision add/sub datapath. It consumes the raw 24-bit mantissa sum, carry-out and guard/round/sticky bits from the mantissa adder/subtractor, together with the pre-add exponent and sign. It renormalizes iteratively, applying one right shift on carry or one left shift per cycle on cancellation. It then rounds to nearest-even and packs an IEEE-754 binary32 result behind a valid/ready handshake.

Parameters:
EXP_W, 8, exponent field width
MANT_W, 24, mantissa width including hidden bit
BIAS, 127, exponent bias (informational; exponents arrive biased)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept a bundle (high only in IDLE)
sign_in  input  1  result sign
exp_in  input  8  biased exponent before normalization; 0 treated as 1
mant_in  input  24  adder sum
carry_in  input  1  adder carry-out (add overflow)
grs_in  input  3  {guard, round, sticky} from alignment shift
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  32  packed binary32
flag_zero  output  1  exact zero result
flag_ovf  output  1  overflow to infinity
flag_unf  output  1  subnormal result

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE; in_ready=1 in the cycle after reset.
  - out_valid=0, result=0, all flags 0.
  - Reset mid-operation aborts the bundle with no output.
- Internal registers:
  - 9-bit exponent, 24-bit mantissa, 3-bit grs.
  - carry_pend bit, sign bit.
- Handshake:
  - Accept on in_valid&in_ready: capture inputs and go to NORM.
  - Result and flags are held stable while out_valid&!out_ready.
  - in_ready is combinational: 1 only in IDLE; no accept in the same cycle as the output handshake.
- FSM: IDLE -> NORM -> ROUND -> DONE -> IDLE.
- NORM (one action per cycle, priority order):
  - carry_pend: mant={1,mant[23:1]}; g=old mant[0]; r=old g; s=old r|s; exp+=1; clear carry_pend; go ROUND.
  - mant==0 && grs==0: mark zero; go ROUND.
  - mant[23]==1 or exp==1: go ROUND.
  - Otherwise, left shift: mant={mant[22:0],g}; g=r; r=0; s unchanged; exp-=1; stay in NORM.
- ROUND (RNE):
  - inc = g & (r | s | mant[0]); mant+=inc.
  - If the increment carries out of bit 23: mant=0x800000, exp+=1.
  - Exponent field = mant[23] ? exp[7:0] : 0. A subnormal that rounds up to 0x800000 becomes exponent 1.
  - If exp>=255: result={sign,8'hFF,23'h0}, flag_ovf=1.
  - Zero: result=32'h0000_0000 (+0 regardless of sign_in), flag_zero=1.
  - flag_unf=1 when the exponent field is 0 and the result is non-zero.
  - Register result; go DONE.
- DONE: out_valid=1; on out_ready go IDLE; out_valid drops the next cycle.
- Latency (accept edge to first out_valid cycle):
  - 3 cycles with no left shift (including the carry case).
  - 3+k cycles with k left shifts; k<=23 for mant_in!=0.
- exp_in>=255 on input: behaviour is undefined; the upstream block never presents it.

Decomposition:
- Package fpu_pkg:
  - EXP_W, MANT_W, BIAS, EXP_MAX=255.
  - Enum norm_state_t {IDLE,NORM,ROUND,DONE}.
  - Packed struct fp32_t {sign, exp[7:0], frac[22:0]}.
- One natural sub-module: fp_round_rne.
  - Combinational.
  - Inputs: mant, grs, exp.
  - Outputs: rounded mant, exp, overflow.
  - Reusable by the multiplier path.

Test Plan:
1. Carry: mant_in=0x800000, carry_in=1, exp_in=0x80, grs=000, sign=0 -> result=0x40C00000, flags 0, out_valid 3 cycles after accept.
2. Cancellation: mant_in=0x000001, exp_in=0x7F, grs=000 -> 23 shifts, result=0x34000000, out_valid 26 cycles after accept.
3. Exact zero: mant_in=0, grs=000, exp_in=0x90, sign=1 -> result=0x00000000, flag_zero=1, latency 3.
4. RNE tie cases, exp_in=0x7F, grs=100:
   - mant_in=0x800001 -> result=0x3F800002.
   - mant_in=0x800000 -> result=0x3F800000.
   - mant_in=0x800000, grs=101 -> result=0x3F800001.
5. Round overflow: mant_in=0xFFFFFF, exp_in=0xFE, grs=110 -> result=0x7F800000, flag_ovf=1. Subnormal: mant_in=0x000100, exp_in=0x03 -> 2 shifts, result=0x00000400, flag_unf=1.
6. Backpressure/reset:
   - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
   - Then out_ready=1 -> IDLE, in_ready=1 the next cycle.
   - Assert rst during NORM of case 2 -> next cycle out_valid=0, in_ready=1, and no result is ever emitted.
